// File: rtl/umstr_axil_reg_if_mux.sv
// umstr_axil_reg_if_mux: AXI-Lite slave fanning out to NUM_PORTS register ports with per-access timeout.
module umstr_axil_reg_if_mux #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_PORTS       = 4,
  parameter int PORT_ADDR_WIDTH = 8,
  parameter int TIMEOUT         = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
  input  logic [2:0]                      s_axil_awprot,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  output logic [1:0]                      s_axil_bresp,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
  input  logic [2:0]                      s_axil_arprot,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  output logic [DATA_WIDTH-1:0]           s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  output logic [PORT_ADDR_WIDTH-1:0]      reg_wr_addr,
  output logic [DATA_WIDTH-1:0]           reg_wr_data,
  output logic [STRB_WIDTH-1:0]           reg_wr_strb,
  output logic [NUM_PORTS-1:0]            reg_wr_en,
  input  logic [NUM_PORTS-1:0]            reg_wr_wait,
  input  logic [NUM_PORTS-1:0]            reg_wr_ack,
  output logic [PORT_ADDR_WIDTH-1:0]      reg_rd_addr,
  output logic [NUM_PORTS-1:0]            reg_rd_en,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] reg_rd_data,
  input  logic [NUM_PORTS-1:0]            reg_rd_wait,
  input  logic [NUM_PORTS-1:0]            reg_rd_ack
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {W_IDLE, W_ACC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACC, R_RESP} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic rdy_en, aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data, rd_sel;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [TW-1:0] w_cnt, r_cnt;
  logic [3:0] w_idx, r_idx;
  logic w_map, r_map, w_ack, w_wait, w_exp, r_ack, r_wait, r_exp, ar_hs, unused_bits;
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot, aw_addr, s_axil_araddr};
  // rdy_en keeps the ready outputs low during reset and rises one cycle after release
  assign s_axil_awready = rdy_en && w_state == W_IDLE && !aw_held;
  assign s_axil_wready  = rdy_en && w_state == W_IDLE && !w_held;
  assign s_axil_arready = rdy_en && r_state == R_IDLE;
  assign ar_hs  = s_axil_arvalid && s_axil_arready;
  assign w_idx  = aw_addr[PORT_ADDR_WIDTH+3:PORT_ADDR_WIDTH];
  assign r_idx  = s_axil_araddr[PORT_ADDR_WIDTH+3:PORT_ADDR_WIDTH];
  assign w_map  = 32'(w_idx) < NUM_PORTS;
  assign r_map  = 32'(r_idx) < NUM_PORTS;
  // the one-hot enable masks out acks and waits from unselected ports
  assign w_ack  = |(reg_wr_ack & reg_wr_en);
  assign w_wait = |(reg_wr_wait & reg_wr_en);
  assign r_ack  = |(reg_rd_ack & reg_rd_en);
  assign r_wait = |(reg_rd_wait & reg_rd_en);
  assign w_exp  = (TIMEOUT != 0) && w_cnt == '0 && !w_wait;
  assign r_exp  = (TIMEOUT != 0) && r_cnt == '0 && !r_wait;
  always_comb begin
    rd_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      rd_sel = rd_sel | (reg_rd_data[p*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{reg_rd_en[p]}});
  end
  always_comb begin
    w_next = w_state;
    if (w_state == W_IDLE && aw_held && w_held) w_next = w_map ? W_ACC : W_RESP;
    if (w_state == W_ACC && (w_ack || w_exp)) w_next = W_RESP;
    if (w_state == W_RESP && s_axil_bready) w_next = W_IDLE;
    r_next = r_state;
    if (r_state == R_IDLE && ar_hs) r_next = r_map ? R_ACC : R_RESP;
    if (r_state == R_ACC && (r_ack || r_exp)) r_next = R_RESP;
    if (r_state == R_RESP && s_axil_rready) r_next = R_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_en <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      w_cnt <= '0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
      reg_wr_en <= '0;
      s_axil_bresp <= 2'b00;
      s_axil_bvalid <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (s_axil_awvalid && s_axil_awready) begin
        aw_held <= 1'b1;
        aw_addr <= s_axil_awaddr;
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_held <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
      if (w_state == W_IDLE && aw_held && w_held) begin
        reg_wr_addr <= aw_addr[PORT_ADDR_WIDTH-1:0];
        reg_wr_data <= w_data;
        reg_wr_strb <= w_strb;
        reg_wr_en <= w_map ? NUM_PORTS'(1) << w_idx : '0;
        w_cnt <= TW'(TIMEOUT - 1);
        s_axil_bresp <= 2'b11;
        s_axil_bvalid <= !w_map;
      end
      if (w_state == W_ACC) begin
        if (w_ack || w_exp) begin
          reg_wr_en <= '0;
          s_axil_bvalid <= 1'b1;
          s_axil_bresp <= w_ack ? 2'b00 : 2'b10;
        end else
          w_cnt <= w_wait ? TW'(TIMEOUT - 1) : w_cnt - TW'(1);
      end
      if (w_state == W_RESP && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
        aw_held <= 1'b0;
        w_held <= 1'b0;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      reg_rd_addr <= '0;
      reg_rd_en <= '0;
      s_axil_rdata <= '0;
      s_axil_rresp <= 2'b00;
      s_axil_rvalid <= 1'b0;
    end else begin
      if (r_state == R_IDLE && ar_hs) begin
        reg_rd_addr <= s_axil_araddr[PORT_ADDR_WIDTH-1:0];
        reg_rd_en <= r_map ? NUM_PORTS'(1) << r_idx : '0;
        r_cnt <= TW'(TIMEOUT - 1);
        s_axil_rdata <= '0;
        s_axil_rresp <= 2'b11;
        s_axil_rvalid <= !r_map;
      end
      if (r_state == R_ACC) begin
        if (r_ack || r_exp) begin
          reg_rd_en <= '0;
          s_axil_rvalid <= 1'b1;
          s_axil_rresp <= r_ack ? 2'b00 : 2'b10;
          s_axil_rdata <= r_ack ? rd_sel : '0;
        end else
          r_cnt <= r_wait ? TW'(TIMEOUT - 1) : r_cnt - TW'(1);
      end
      if (r_state == R_RESP && s_axil_rready) s_axil_rvalid <= 1'b0;
    end
endmodule

// File: tb/tb_umstr_axil_reg_if_mux.sv
// tb_umstr_axil_reg_if_mux: scoreboard bench with randomized port responders and a timing-rule reference model.
module tb_umstr_axil_reg_if_mux;
  localparam int DW = 32, AW = 32, SW = 4, NP = 4, PAW = 8, TO = 16;
  logic clk = 0, rst_n = 0;
  logic [AW-1:0] s_axil_awaddr = '0, s_axil_araddr = '0;
  logic [2:0] s_axil_awprot = '0, s_axil_arprot = '0;
  logic s_axil_awvalid = 0, s_axil_wvalid = 0, s_axil_bready = 0, s_axil_arvalid = 0, s_axil_rready = 0;
  logic s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [DW-1:0] s_axil_wdata = '0, s_axil_rdata, reg_wr_data;
  logic [SW-1:0] s_axil_wstrb = '0, reg_wr_strb;
  logic [1:0] s_axil_bresp, s_axil_rresp;
  logic [PAW-1:0] reg_wr_addr, reg_rd_addr;
  logic [NP-1:0] reg_wr_en, reg_rd_en;
  logic [NP-1:0] reg_wr_wait = '0, reg_wr_ack = '0, reg_rd_wait = '0, reg_rd_ack = '0;
  logic [NP*DW-1:0] reg_rd_data = '0;
  always #5 clk = ~clk;
  umstr_axil_reg_if_mux #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .NUM_PORTS(NP),
    .PORT_ADDR_WIDTH(PAW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready), .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr),
    .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb), .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack));

  typedef struct {int port; logic [PAW-1:0] off; logic [DW-1:0] data; logic [SW-1:0] strb;
                  int w; int a; bit noack; int cyc;} plan_t;
  typedef struct {logic [1:0] resp; logic [DW-1:0] data;} exp_t;
  plan_t wplan[$], rplan[$];
  exp_t bq[$], rq[$];
  int tests = 0, fails = 0;
  bit hold_b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder holds wait for w enable cycles, then acks a cycles later; the outcome follows from the
  // timeout rule: w wait cycles never count, and TO non-wait cycles are allowed with the last one able to ack.
  function automatic void model(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                                input int w, input int a, input bit noack, output plan_t p, output exp_t e);
    p.port = int'((addr >> PAW) % 16);
    p.off = addr[PAW-1:0];
    p.data = data; p.strb = strb; p.w = w; p.a = a; p.noack = noack;
    e.data = '0;
    if (p.port >= NP) begin e.resp = 2'b11; p.cyc = 0; end
    else if (noack || a >= TO) begin e.resp = 2'b10; p.cyc = w + TO; end
    else begin e.resp = 2'b00; e.data = data; p.cyc = w + a + 1; end
  endfunction

  int wk = 0, rk = 0;
  plan_t wc, rc;
  always @(negedge clk) begin
    if (!rst_n) wk = 0;
    else if (reg_wr_en != 0) begin
      if (wk == 0) begin
        chk("wr_plan_avail", 64'(wplan.size() != 0), 1);
        if (wplan.size() != 0) wc = wplan.pop_front();
        chk("wr_en_onehot", 64'(reg_wr_en), 64'(1) << wc.port);
        chk("wr_addr", 64'(reg_wr_addr), 64'(wc.off));
        chk("wr_data", 64'(reg_wr_data), 64'(wc.data));
        chk("wr_strb", 64'(reg_wr_strb), 64'(wc.strb));
      end
      wk++;
      reg_wr_wait = NP'($urandom);
      reg_wr_ack = NP'($urandom);
      reg_wr_wait[wc.port] = wk <= wc.w;
      reg_wr_ack[wc.port] = !wc.noack && wk == wc.w + wc.a + 1;
    end else begin
      if (wk > 0) begin
        chk("wr_en_cycles", 64'(wk), 64'(wc.cyc));
        chk("bvalid_after_en", 64'(s_axil_bvalid), 1);
      end
      wk = 0;
      reg_wr_wait = NP'($urandom);
      reg_wr_ack = NP'($urandom);
    end
  end
  always @(negedge clk) begin
    if (!rst_n) rk = 0;
    else if (reg_rd_en != 0) begin
      if (rk == 0) begin
        chk("rd_plan_avail", 64'(rplan.size() != 0), 1);
        if (rplan.size() != 0) rc = rplan.pop_front();
        chk("rd_en_onehot", 64'(reg_rd_en), 64'(1) << rc.port);
        chk("rd_addr", 64'(reg_rd_addr), 64'(rc.off));
      end
      rk++;
      for (int i = 0; i < NP; i++) reg_rd_data[i*DW +: DW] = $urandom;
      reg_rd_data[rc.port*DW +: DW] = rc.data;
      reg_rd_wait = NP'($urandom);
      reg_rd_ack = NP'($urandom);
      reg_rd_wait[rc.port] = rk <= rc.w;
      reg_rd_ack[rc.port] = !rc.noack && rk == rc.w + rc.a + 1;
    end else begin
      if (rk > 0) begin
        chk("rd_en_cycles", 64'(rk), 64'(rc.cyc));
        chk("rvalid_after_en", 64'(s_axil_rvalid), 1);
      end
      rk = 0;
      reg_rd_wait = NP'($urandom);
      reg_rd_ack = NP'($urandom);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && s_axil_bvalid) begin
      s_axil_bready = !hold_b && $urandom_range(0, 2) != 0;
      if (s_axil_bready) begin
        chk("b_expected", 64'(bq.size() != 0), 1);
        if (bq.size() != 0) begin
          e = bq.pop_front();
          chk("bresp", 64'(s_axil_bresp), 64'(e.resp));
        end
      end
    end else s_axil_bready = 0;
  end
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && s_axil_rvalid) begin
      s_axil_rready = $urandom_range(0, 2) != 0;
      if (s_axil_rready) begin
        chk("r_expected", 64'(rq.size() != 0), 1);
        if (rq.size() != 0) begin
          e = rq.pop_front();
          chk("rresp", 64'(s_axil_rresp), 64'(e.resp));
          chk("rdata", 64'(s_axil_rdata), 64'(e.data));
        end
      end
    end else s_axil_rready = 0;
  end

  task automatic issue_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                             input int w, input int a, input bit noack, input int da, input int dw);
    plan_t p; exp_t e; bit ad = 0, wd = 0, early = 0; int t = 0;
    model(addr, data, strb, w, a, noack, p, e);
    if (p.port < NP) wplan.push_back(p);
    bq.push_back(e);
    while (!(ad && wd) && t < 100) begin
      @(negedge clk);
      if (reg_wr_en != 0) early = 1;
      s_axil_awvalid = !ad && t >= da;
      s_axil_wvalid = !wd && t >= dw;
      s_axil_awaddr = addr; s_axil_awprot = 3'($urandom);
      s_axil_wdata = data; s_axil_wstrb = strb;
      if (s_axil_awvalid && s_axil_awready) ad = 1;
      if (s_axil_wvalid && s_axil_wready) wd = 1;
      t++;
    end
    @(negedge clk);
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    chk("wr_handshake", 64'(ad && wd), 1);
    chk("wr_no_early_en", 64'(early), 0);
  endtask
  task automatic wait_b();
    int t = 0;
    while (bq.size() != 0 && t < 300) begin @(negedge clk); t++; end
    chk("wr_complete", 64'(bq.size()), 0);
  endtask
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                          input int w, input int a, input bit noack, input int da, input int dw);
    issue_write(addr, data, strb, w, a, noack, da, dw);
    wait_b();
  endtask
  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int w, input int a,
                         input bit noack, input int da);
    plan_t p; exp_t e; bit hs = 0; int t = 0;
    model(addr, data, '0, w, a, noack, p, e);
    if (p.port < NP) rplan.push_back(p);
    rq.push_back(e);
    while (!hs && t < 100) begin
      @(negedge clk);
      s_axil_arvalid = t >= da;
      s_axil_araddr = addr; s_axil_arprot = 3'($urandom);
      if (s_axil_arvalid && s_axil_arready) hs = 1;
      t++;
    end
    @(negedge clk);
    s_axil_arvalid = 0;
    chk("rd_handshake", 64'(hs), 1);
    t = 0;
    while (rq.size() != 0 && t < 300) begin @(negedge clk); t++; end
    chk("rd_complete", 64'(rq.size()), 0);
  endtask
  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] ad = $urandom;
    ad[PAW+3:PAW] = ($urandom % 5 == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
    return ad;
  endfunction

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(s_axil_awready), 0);
    chk("rst_wready", 64'(s_axil_wready), 0);
    chk("rst_arready", 64'(s_axil_arready), 0);
    chk("rst_valids", 64'({s_axil_bvalid, s_axil_rvalid}), 0);
    chk("rst_enables", 64'({reg_wr_en, reg_rd_en}), 0);
    chk("rst_data", 64'({s_axil_bresp, s_axil_rresp, s_axil_rdata}), 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'h7);
    do_write(32'h0104, 32'hDEADBEEF, 4'hF, 0, 2, 0, 0, 0);
    do_write(32'h0008, 32'hCAFE0001, 4'h3, 0, 0, 0, 2, 0);
    do_read(32'h0310, 32'h12345678, 0, 0, 0, 0);
    do_read(32'h0500, 32'h55555555, 0, 0, 0, 0);
    do_write(32'h0500, 32'h1, 4'h1, 0, 0, 0, 0, 1);
    do_write(32'h0220, 32'h2, 4'hF, 0, 0, 1, 0, 0);
    do_write(32'h0224, 32'h3, 4'hF, 20, 0, 0, 1, 0);
    do_write(32'h0228, 32'h4, 4'hF, 0, TO - 1, 0, 0, 0);
    do_write(32'h022C, 32'h5, 4'hF, 0, TO, 0, 0, 0);
    do_read(32'h0204, 32'h6, 3, TO - 1, 0, 1);
    do_read(32'h0108, 32'h7, 0, 0, 1, 0);
    hold_b = 1;
    issue_write(32'h0314, 32'hA5A5A5A5, 4'hC, 0, 1, 0, 0, 0);
    t = 0;
    while (!s_axil_bvalid && t < 50) begin @(negedge clk); t++; end
    repeat (5) begin
      @(negedge clk);
      chk("bvalid_held", 64'(s_axil_bvalid), 1);
      chk("awready_stalled", 64'(s_axil_awready), 0);
    end
    hold_b = 0;
    wait_b();
    issue_write(32'h0200, 32'h77, 4'hF, 0, 0, 1, 0, 0);
    t = 0;
    while (reg_wr_en == 0 && t < 50) begin @(negedge clk); t++; end
    chk("rst_test_en_seen", 64'(reg_wr_en), 64'h4);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midacc_rst_bvalid", 64'(s_axil_bvalid), 0);
    chk("midacc_rst_en", 64'(reg_wr_en), 0);
    chk("midacc_rst_awready", 64'(s_axil_awready), 0);
    wplan.delete(); bq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_write(32'h0104, 32'h600DF00D, 4'hF, 1, 1, 0, 0, 0);
    fork
      repeat (40) do_write(rand_addr(), $urandom, SW'($urandom),
        ($urandom % 6 == 0) ? $urandom_range(5, 20) : $urandom_range(0, 2),
        $urandom_range(0, 17), $urandom % 8 == 0, $urandom_range(0, 3), $urandom_range(0, 3));
      repeat (40) do_read(rand_addr(), $urandom,
        ($urandom % 6 == 0) ? $urandom_range(5, 20) : $urandom_range(0, 2),
        $urandom_range(0, 17), $urandom % 8 == 0, $urandom_range(0, 3));
    join
    repeat (5) @(negedge clk);
    chk("queues_drained", 64'(bq.size() + rq.size() + wplan.size() + rplan.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
